// File: rtl/adder_tree_ctrl.sv
// Burst sequencer for a pipelined signed adder tree: gates NUM chunks into the tree,
// tracks tree latency with a valid shift register and accumulates the returning sums.
module adder_tree_ctrl #(
  parameter int TREE_LATENCY = 3,
  parameter int CNT_W        = 8,
  parameter int SUM_W        = 32,
  parameter int ACC_W        = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        num_chunks_i,
  input  logic                    abort_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic                    tree_gate_o,
  input  logic signed [SUM_W-1:0] tree_sum_i,
  output logic                    busy_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic signed [ACC_W-1:0] result_o,
  output logic                    result_ovf_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         num_q, num_d;
  logic [CNT_W-1:0]         sent_q, sent_d;
  logic [CNT_W-1:0]         ret_q, ret_d;
  logic [TREE_LATENCY-1:0]  vpipe_q, vpipe_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  result_q, result_d;
  logic                     ovf_q, ovf_d;
  logic                     result_ovf_q, result_ovf_d;

  logic                     hs_s;
  logic                     ret_s;
  logic signed [ACC_W-1:0]  sum_ext_s;
  logic signed [ACC_W-1:0]  acc_sum_s;
  logic                     add_ovf_s;

  assign in_ready_o     = (state_q == FEED);
  assign tree_gate_o    = in_valid_i & in_ready_o;
  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = (state_q == DONE);
  assign result_o       = result_q;
  assign result_ovf_o   = result_ovf_q;

  assign hs_s      = tree_gate_o;
  assign ret_s     = vpipe_q[TREE_LATENCY-1];
  assign sum_ext_s = ACC_W'(tree_sum_i);
  assign acc_sum_s = acc_q + sum_ext_s;
  // Two's-complement overflow: same-sign operands producing an opposite-sign sum.
  assign add_ovf_s = (acc_q[ACC_W-1] == sum_ext_s[ACC_W-1]) &&
                     (acc_sum_s[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    sent_d       = sent_q;
    ret_d        = ret_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    result_d     = result_q;
    result_ovf_d = result_ovf_q;
    vpipe_d      = (vpipe_q << 1) | TREE_LATENCY'(hs_s);

    if (abort_i) begin
      // In-flight sums are dropped by flushing the valid pipeline.
      state_d = IDLE;
      vpipe_d = '0;
      sent_d  = '0;
      ret_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            num_d  = num_chunks_i;
            sent_d = '0;
            ret_d  = '0;
            acc_d  = '0;
            ovf_d  = 1'b0;
            if (num_chunks_i == '0) begin
              state_d      = DONE;
              result_d     = '0;
              result_ovf_d = 1'b0;
            end else begin
              state_d = FEED;
            end
          end else begin
            state_d = IDLE;
          end
        end
        FEED, DRAIN: begin
          if (hs_s) begin
            sent_d = sent_q + CNT_W'(1);
            if (sent_q == num_q - CNT_W'(1)) begin
              state_d = DRAIN;
            end else begin
              state_d = state_q;
            end
          end else begin
            sent_d = sent_q;
          end
          if (ret_s) begin
            acc_d = acc_sum_s;
            ovf_d = ovf_q | add_ovf_s;
            ret_d = ret_q + CNT_W'(1);
            // Snapshot on the final add so the result holds through the next burst.
            if (ret_q == num_q - CNT_W'(1)) begin
              state_d      = DONE;
              result_d     = acc_sum_s;
              result_ovf_d = ovf_q | add_ovf_s;
            end else begin
              result_d = result_q;
            end
          end else begin
            ret_d = ret_q;
          end
        end
        DONE: begin
          if (result_ready_i) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_q        <= '0;
      sent_q       <= '0;
      ret_q        <= '0;
      vpipe_q      <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      sent_q       <= sent_d;
      ret_q        <= ret_d;
      vpipe_q      <= vpipe_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      result_q     <= result_d;
      result_ovf_q <= result_ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_tree_ctrl.sv
// Scoreboard bench for adder_tree_ctrl: 40-bit and 36-bit accumulators driven in parallel,
// with a cycle-scheduled tree model and a wrapping-arithmetic reference.
module tb_adder_tree_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        result_ready_i = 1'b0;
  logic [7:0]  num_chunks_i = 8'd0;
  logic signed [31:0] tree_sum_i = 32'sd0;

  logic        in_ready_o, tree_gate_o, busy_o, result_valid_o, result_ovf_o;
  logic [39:0] result_o;
  logic        in_ready36, tree_gate36, busy36, rv36, ovf36;
  logic [35:0] result36;

  typedef struct packed {
    logic [39:0] r40;
    logic        o40;
    logic [35:0] r36;
    logic        o36;
  } exp_t;

  int        n_vec = 0;
  int        n_err = 0;
  int        cyc = 0;
  int signed chunk_vals [256];
  int signed sched [int];
  exp_t      exp_q [$];
  exp_t      mon_e;

  always #5 clk = ~clk;

  adder_tree_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_chunks_i(num_chunks_i),
    .abort_i(abort_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .tree_gate_o(tree_gate_o), .tree_sum_i(tree_sum_i), .busy_o(busy_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o), .result_ovf_o(result_ovf_o)
  );

  adder_tree_ctrl #(.ACC_W(36)) u_dut36 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_chunks_i(num_chunks_i),
    .abort_i(abort_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready36),
    .tree_gate_o(tree_gate36), .tree_sum_i(tree_sum_i), .busy_o(busy36),
    .result_valid_o(rv36), .result_ready_i(result_ready_i),
    .result_o(result36), .result_ovf_o(ovf36)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint wrapw(input longint s, input int w);
    longint span;
    span = longint'(1) <<< w;
    if (s > (span >>> 1) - 1) return s - span;
    else if (s < -(span >>> 1)) return s + span;
    return s;
  endfunction

  // Reference: plain integer sum, wrapped to the accumulator width after every add.
  function automatic exp_t model(input int n);
    exp_t   e;
    longint a40, a36, s;
    logic   o40, o36;
    a40 = 0; a36 = 0; o40 = 1'b0; o36 = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = a40 + longint'(chunk_vals[i]);
      if (wrapw(s, 40) != s) o40 = 1'b1;
      a40 = wrapw(s, 40);
      s = a36 + longint'(chunk_vals[i]);
      if (wrapw(s, 36) != s) o36 = 1'b1;
      a36 = wrapw(s, 36);
    end
    e.r40 = a40[39:0];
    e.o40 = o40;
    e.r36 = a36[35:0];
    e.o36 = o36;
    return e;
  endfunction

  // One clock cycle of stimulus; the tree model returns each accepted chunk LAT cycles later.
  task automatic cyc_drive(input logic v, input logic st, input logic ab, input logic rr,
                           input logic [7:0] n, input int signed val, output logic hs);
    @(posedge clk);
    cyc++;
    #2;
    in_valid_i     = v;
    start_i        = st;
    abort_i        = ab;
    result_ready_i = rr;
    num_chunks_i   = n;
    hs = v && in_ready_o;
    if (hs) sched[cyc + LAT] = val;
    if (sched.exists(cyc)) begin
      tree_sum_i = sched[cyc];
      sched.delete(cyc);
    end else begin
      tree_sum_i = $urandom;
    end
    #1;
    chk("tree_gate", tree_gate_o, hs);
    chk("tree_gate36", tree_gate36, hs);
  endtask

  task automatic burst(input int n, input int bubble_pct, input int abort_at,
                       input int rr_hold, input int exp_lat);
    logic hs, v, ab;
    int   idx, budget, h0, tv, after, start_cyc, ref_cyc;
    bit   aborted, first;
    idx = 0; h0 = -1; tv = -1; after = 0; aborted = 1'b0; first = 1'b1;
    budget = 0;
    while (busy_o && budget < 100) begin
      cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 0, hs);
      budget++;
    end
    chk("idle_before_start", busy_o, 1'b0);
    cyc_drive(1'b0, 1'b1, 1'b0, 1'b0, 8'(n), 0, hs);
    start_cyc = cyc;
    if (abort_at < 0) exp_q.push_back(model(n));
    budget = 0;
    while (!aborted && (idx < n || abort_at >= 0) && budget < 3000) begin
      v  = ($urandom_range(99) >= bubble_pct);
      ab = (abort_at >= 0) && (after == 2);
      cyc_drive(v, 1'b0, ab, 1'b1, 8'd0, chunk_vals[idx], hs);
      if (ab) begin
        aborted = 1'b1;
      end else begin
        if (hs) begin
          if (h0 < 0) h0 = cyc;
          idx++;
        end
        if (abort_at >= 0 && idx >= abort_at) after++;
      end
      budget++;
    end
    if (abort_at >= 0) begin
      chk("abort_reached", aborted, 1'b1);
      cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 0, hs);
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_result_valid", result_valid_o, 1'b0);
      return;
    end
    chk("chunks_accepted", idx, n);
    budget = 0;
    while (tv < 0 && budget < 600) begin
      cyc_drive(1'($urandom_range(1)), 1'b0, 1'b0, (rr_hold == 0), 8'd0, 0, hs);
      if (first) begin
        chk("in_ready_after_last", in_ready_o, 1'b0);
        first = 1'b0;
      end
      if (result_valid_o) tv = cyc;
      budget++;
    end
    chk("result_seen", (tv >= 0), 1'b1);
    if (tv < 0) return;
    ref_cyc = (n == 0) ? start_cyc : h0;
    if (exp_lat >= 0) chk("result_latency", tv - ref_cyc, exp_lat);
    for (int k = 1; k < rr_hold; k++) begin
      cyc_drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 0, hs);
      chk("result_valid_held", result_valid_o, 1'b1);
    end
    if (rr_hold > 0) cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 0, hs);
    cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 0, hs);
    chk("busy_after_result", busy_o, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every result handshake, checks stability while stalled.
  initial begin : monitor
    logic [39:0] prev40;
    logic        prev_ovf;
    bit          holding;
    holding = 1'b0;
    prev40 = '0;
    prev_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 1'b0;
      end else if (result_valid_o) begin
        chk("rv36_align", rv36, 1'b1);
        if (holding) begin
          chk("result_stable", result_o, prev40);
          chk("result_ovf_stable", result_ovf_o, prev_ovf);
        end
        if (result_ready_i) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got 0x%0h, expected no result", result_o);
          end else begin
            mon_e = exp_q.pop_front();
            chk("result40", result_o, mon_e.r40);
            chk("result_ovf40", result_ovf_o, mon_e.o40);
            chk("result36", result36, mon_e.r36);
            chk("result_ovf36", ovf36, mon_e.o36);
          end
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          prev40 = result_o;
          prev_ovf = result_ovf_o;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, mode, bub, ab_at, hold, lat;
    bit sgn;
    #12;
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_result_valid", result_valid_o, 1'b0);
    chk("rst_result", result_o, 40'd0);
    chk("rst_result_ovf", result_ovf_o, 1'b0);
    chk("rst_in_ready36", in_ready36, 1'b0);
    chk("rst_busy36", busy36, 1'b0);
    rst_n = 1'b1;

    chunk_vals[0] = 1000;
    burst(1, 0, -1, 0, 1 + LAT);

    chunk_vals[0] = 5; chunk_vals[1] = -7; chunk_vals[2] = 100; chunk_vals[3] = -32768;
    burst(4, 0, -1, 0, 4 + LAT);

    chunk_vals[0] = 10; chunk_vals[1] = 20; chunk_vals[2] = 30;
    burst(3, 60, -1, 0, -1);

    burst(0, 0, -1, 0, 1);

    for (int i = 0; i < 255; i++) chunk_vals[i] = 32'h7FFFFFFF;
    burst(255, 0, -1, 0, 255 + LAT);

    chunk_vals[0] = 5; chunk_vals[1] = -7; chunk_vals[2] = 100; chunk_vals[3] = -32768;
    burst(4, 0, 2, 0, -1);
    chunk_vals[0] = 9;
    burst(1, 0, -1, 0, 1 + LAT);

    chunk_vals[0] = 123; chunk_vals[1] = -456; chunk_vals[2] = 789;
    burst(3, 0, -1, 5, -1);

    for (int t = 0; t < 25; t++) begin
      mode = $urandom_range(2);
      sgn  = 1'($urandom_range(1));
      n    = (mode == 2) ? $urandom_range(40) : $urandom_range(20);
      for (int i = 0; i < n; i++) begin
        case (mode)
          0: chunk_vals[i] = int'($urandom_range(2000)) - 1000;
          1: chunk_vals[i] = $urandom;
          default: chunk_vals[i] = sgn ? int'(32'h7FFF0000) + int'($urandom_range(65535))
                                       : int'(32'h80000000) + int'($urandom_range(65535));
        endcase
      end
      bub   = ($urandom_range(2) == 0) ? 0 : $urandom_range(60);
      hold  = $urandom_range(3);
      ab_at = (n >= 2 && $urandom_range(5) == 0) ? $urandom_range(n - 1, 1) : -1;
      lat   = (n == 0) ? 1 : ((bub == 0) ? n + LAT : -1);
      burst(n, bub, ab_at, hold, lat);
    end

    repeat (4) begin
      @(posedge clk);
      #2;
      in_valid_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; result_ready_i = 1'b1;
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_tree_ctrl.md
Name: adder_tree_ctrl

Overview:
- Sequencer for the 128-input, 3-register-latency signed adder tree. It accepts a burst of NUM chunks from an upstream valid/ready stream and gates each accepted chunk into the tree.
- It tracks the tree latency with a valid pipeline and accumulates the per-chunk tree sums into a wide signed accumulator.
- It presents one result per burst on a valid/ready output. This lets dot products longer than 128 elements reuse a single tree.

Parameters:
- TREE_LATENCY, 3, cycles from a chunk being presented to the tree to its sum appearing on tree_sum.
- CNT_W, 8, width of the chunk counter; max burst = 2^CNT_W-1 chunks.
- SUM_W, 32, width of tree_sum (signed).
- ACC_W, 40, width of the accumulator and result (signed); must be >= SUM_W.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  burst start pulse; sampled only in IDLE.
- num_chunks  in  CNT_W  burst length; latched on accepted start.
- abort  in  1  synchronous abort, highest priority after reset.
- in_valid  in  1  upstream chunk valid; data itself bypasses this block.
- in_ready  out  1  chunk accepted when in_valid & in_ready.
- tree_gate  out  1  =in_valid & in_ready (combinational); external mux drives the tree with the chunk when 1, all-zero when 0.
- tree_sum  in  SUM_W  adder tree registered output.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  burst result available.
- result_ready  in  1  downstream accepts the result.
- result  out  ACC_W  signed burst sum.
- result_ovf  out  1  sticky overflow flag for the reported burst.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - in_ready=0, busy=0, result_valid=0, result=0, result_ovf=0.
  - Counters, accumulator and valid pipeline are cleared.
- Timing reference: a chunk accepted in cycle c (handshake true in cycle c) has its sum valid on tree_sum during cycle c+TREE_LATENCY. The controller adds it at the rising edge ending that cycle.
  - Back-to-back chunks produce back-to-back sums.
  - The valid pipeline is TREE_LATENCY deep (plus any alignment stage the implementation needs). It shifts every cycle and inserts 0 when there is no handshake.
- IDLE state:
  - in_ready=0, result_valid=0.
  - start=1 with num_chunks>0: latch num_chunks, clear acc, sent_cnt, ret_cnt and ovf, then go to FEED.
  - start=1 with num_chunks=0: latch it, acc=0, then go to DONE on the next cycle.
- FEED state:
  - in_ready=1.
  - Each handshake increments sent_cnt.
  - The handshake where sent_cnt==num_chunks-1 moves the state to DRAIN. in_ready is 0 from the next cycle.
- DRAIN state:
  - in_ready=0.
  - When ret_cnt reaches num_chunks (the last sum has been added), go to DONE.
- Accumulation, in any of FEED/DRAIN:
  - On each returning valid: acc <= acc + sign_extend(tree_sum to ACC_W), and ret_cnt++.
  - Returns may overlap feeding.
- Overflow: if the operand signs match and the sum sign differs, set ovf (sticky for the burst). acc wraps (two's complement); it does not saturate.
- DONE state:
  - result_valid=1; result=acc and result_ovf=ovf, held stable until the handshake.
  - result_valid & result_ready: go to IDLE. result and result_ovf keep their last values.
  - start while not in IDLE is ignored and not queued.
- abort=1 in any state:
  - Next state is IDLE; the valid pipeline, counters and acc are cleared; result_valid drops.
  - Sums of in-flight chunks are discarded, never accumulated.
  - If abort and start are both asserted, abort wins.
- in_valid low mid-burst: no handshake, tree_gate=0 and a bubble enters the pipeline. The burst simply stretches and the result is unaffected.
- Reset mid-burst: immediate return to IDLE with all outputs at their reset values.
- sent_cnt, ret_cnt: CNT_W bits; no wrap is possible since both are bounded by num_chunks.

Test Plan:
- Single chunk: start, num_chunks=1, one chunk with tree_sum=1000 returned TREE_LATENCY cycles later -> result_valid with result=1000, ovf=0; busy drops after the result_ready handshake.
- Back-to-back burst: num_chunks=4, in_valid held high, sums 5, -7, 100, -32768 -> exactly 4 handshakes, in_ready=0 after the 4th, result=-32670, result_valid in cycle 4+TREE_LATENCY.
- Bubbles: num_chunks=3, in_valid pattern 1,0,0,1,0,1, sums 10, 20, 30 -> tree_gate=0 in the gap cycles, result=60.
- Zero length: start with num_chunks=0 -> DONE next cycle, result=0, no in_ready.
- Overflow at ACC_W=40: 300 chunks of tree_sum=0x7FFFFFFF is not possible (num_chunks max is 255); instead preload via 255 chunks of 0x7FFFFFFF at ACC_W=36 -> result_ovf=1, result equals the wrapped 36-bit value.
- Abort and backpressure: abort two cycles after the 2nd handshake of a 4-chunk burst -> IDLE next cycle, and a later burst (num_chunks=1, sum=9) returns result=9 with no stale sums. Separately, hold result_ready=0 for 5 cycles -> result stays stable and start is ignored.
